// File: rtl/sram_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_responder_pkg : shared types, defaults and helpers               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sram_responder_pkg;

  localparam int MEM_DEPTH    = 1024;
  localparam int MEM_READ_LAT = 2;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_READ  = 2'd2,
    S_WHOLD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_t;

  // Strobes are active low; WE wins over OE.
  function automatic req_t decode_req(input logic ce_n, input logic oe_n, input logic we_n);
    if (ce_n) return REQ_NONE;
    if (!we_n) return REQ_WRITE;
    if (!oe_n) return REQ_READ;
    return REQ_NONE;
  endfunction

  function automatic logic [15:0] lane_mask(input logic [15:0] d, input logic ub_n,
                                            input logic lb_n, input logic ok);
    lane_mask[15:8] = (ub_n || !ok) ? 8'h00 : d[15:8];
    lane_mask[7:0]  = (lb_n || !ok) ? 8'h00 : d[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_responder_if : SLC-3 SRAM control bus (CPU = master)             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface sram_responder_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] A;
  logic              CE;
  logic              UB;
  logic              LB;
  logic              OE;
  logic              WE;
  logic [15:0]       Data_in;
  logic [15:0]       Data_out;
  logic              Data_oe;
  logic              Busy;
  logic              Range_err;

  modport master (
    output A, CE, UB, LB, OE, WE, Data_in,
    input  Data_out, Data_oe, Busy, Range_err
  );

  modport slave (
    input  A, CE, UB, LB, OE, WE, Data_in,
    output Data_out, Data_oe, Busy, Range_err
  );
endinterface
`default_nettype wire

// File: rtl/sram_responder_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_responder_array : single-port DEPTH x 16 RAM, byte write enables,|
// | registered read (read-before-write on a shared address)               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sram_responder_array
  import sram_responder_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wire logic             clk,
  input  wire logic [1:0]       i_be,
  input  wire logic [IDX_W-1:0] i_addr,
  input  wire logic [15:0]      i_wdata,
  output logic      [15:0]      o_rdata
);

  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_be[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
    if (i_be[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sram_responder : cycle-accurate SRAM responder with byte lanes,       |
// | power-on clear, fixed read latency and address range checking         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DEPTH      = MEM_DEPTH,
  parameter int READ_LAT   = MEM_READ_LAT,
  parameter int INIT_CLEAR = 1
) (
  input wire logic        Clk,
  input wire logic        Reset,
  sram_responder_if.slave bus
);

  localparam int              IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]      c_LAT_LOAD  = 3'(READ_LAT - 1);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DEPTH - 1);
  localparam state_t          c_RST_STATE = (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]  r_clr_idx, w_clr_nxt;
  logic [15:0]       r_dout, w_dout_nxt;
  logic              r_oe, w_oe_nxt;
  logic              r_rerr, w_rerr_nxt;

  req_t              w_req;
  logic              w_in_range;
  logic              w_rd_ok;
  logic              w_go_wr;
  logic              w_go_rd;
  logic [1:0]        w_be;
  logic [IDX_W-1:0]  w_arr_addr;
  logic [15:0]       w_arr_wdata;
  logic [15:0]       w_rdata;

  assign w_req      = decode_req(bus.CE, bus.OE, bus.WE);
  // Full-width compare so high address bits can never alias into the array.
  assign w_in_range = (32'(bus.A) < 32'(DEPTH));
  assign w_rd_ok    = (32'(r_addr) < 32'(DEPTH));

  sram_responder_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (Clk),
    .i_be    (w_be),
    .i_addr  (w_arr_addr),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_clr_nxt   = r_clr_idx;
    w_dout_nxt  = r_dout;
    w_oe_nxt    = r_oe;
    w_rerr_nxt  = 1'b0;
    w_go_wr     = 1'b0;
    w_go_rd     = 1'b0;
    w_be        = 2'b00;
    w_arr_addr  = bus.A[IDX_W-1:0];
    w_arr_wdata = bus.Data_in;

    case (r_state)
      S_CLEAR: begin
        w_arr_addr  = r_clr_idx;
        w_arr_wdata = 16'h0000;
        w_be        = 2'b11;
        w_oe_nxt    = 1'b0;
        if (r_clr_idx == c_LAST_IDX) w_state_nxt = S_IDLE;
        else                         w_clr_nxt   = r_clr_idx + 1'b1;
      end
      S_IDLE: begin
        w_oe_nxt = 1'b0;
        w_go_wr  = (w_req == REQ_WRITE);
        w_go_rd  = (w_req == REQ_READ);
      end
      S_WHOLD: begin
        // A held write commits once; a following read may start without an idle gap.
        w_oe_nxt = 1'b0;
        if (w_req != REQ_WRITE) begin
          w_go_rd     = (w_req == REQ_READ);
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (w_req == REQ_WRITE) begin
          w_go_wr = 1'b1;
        end else if (w_req == REQ_READ) begin
          if (bus.A != r_addr) begin
            w_go_rd = 1'b1;
          end else if (r_cnt == 3'd0) begin
            w_oe_nxt   = 1'b1;
            w_dout_nxt = lane_mask(w_rdata, bus.UB, bus.LB, w_rd_ok);
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end else begin
          w_oe_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_go_wr) begin
      w_be        = {~bus.UB, ~bus.LB} & {2{w_in_range}};
      w_rerr_nxt  = ~w_in_range;
      w_oe_nxt    = 1'b0;
      w_state_nxt = S_WHOLD;
    end
    if (w_go_rd) begin
      w_addr_nxt  = bus.A;
      w_cnt_nxt   = c_LAT_LOAD;
      w_rerr_nxt  = ~w_in_range;
      w_oe_nxt    = 1'b0;
      w_state_nxt = S_READ;
    end

    if (Reset) w_be = 2'b00;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= c_RST_STATE;
      r_addr    <= '0;
      r_cnt     <= 3'd0;
      r_clr_idx <= '0;
      r_dout    <= 16'h0000;
      r_oe      <= 1'b0;
      r_rerr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clr_idx <= w_clr_nxt;
      r_dout    <= w_dout_nxt;
      r_oe      <= w_oe_nxt;
      r_rerr    <= w_rerr_nxt;
    end
  end

  assign bus.Data_out  = r_dout;
  assign bus.Data_oe   = r_oe;
  assign bus.Busy      = (r_state == S_CLEAR);
  assign bus.Range_err = r_rerr;

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sram_responder : directed + random bench against a word-array model|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sram_responder;

  localparam int RL  = 2;
  localparam int DEP = 1024;

  logic        Clk = 1'b0;
  logic        rst_a, rst_b;
  logic [19:0] A;
  logic        CE, UB, LB, OE, WE;
  logic [15:0] Data_in;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mem_m [DEP];

  sram_responder_if #(.ADDR_W(20)) bus_a ();
  sram_responder_if #(.ADDR_W(20)) bus_b ();

  assign bus_a.A = A;  assign bus_a.CE = CE; assign bus_a.UB = UB; assign bus_a.LB = LB;
  assign bus_a.OE = OE; assign bus_a.WE = WE; assign bus_a.Data_in = Data_in;
  assign bus_b.A = A;  assign bus_b.CE = CE; assign bus_b.UB = UB; assign bus_b.LB = LB;
  assign bus_b.OE = OE; assign bus_b.WE = WE; assign bus_b.Data_in = Data_in;

  sram_responder #(.ADDR_W(20), .DEPTH(DEP), .READ_LAT(RL), .INIT_CLEAR(1)) dut_a (
    .Clk(Clk), .Reset(rst_a), .bus(bus_a));
  sram_responder #(.ADDR_W(20), .DEPTH(DEP), .READ_LAT(RL), .INIT_CLEAR(0)) dut_b (
    .Clk(Clk), .Reset(rst_b), .bus(bus_b));

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [19:0] a, input logic ub, input logic lb);
    logic [15:0] w;
    if (a >= 20'(DEP)) return 16'h0000;
    w = mem_m[a[9:0]];
    if (ub) w[15:8] = 8'h00;
    if (lb) w[7:0]  = 8'h00;
    return w;
  endfunction

  function automatic void model_write(input logic [19:0] a, input logic [15:0] d,
                                      input logic ub, input logic lb);
    if (a < 20'(DEP)) begin
      if (!ub) mem_m[a[9:0]][15:8] = d[15:8];
      if (!lb) mem_m[a[9:0]][7:0]  = d[7:0];
    end
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input string tag);
    CE = 1'b1; OE = 1'b1; WE = 1'b1;
    step();
    chk({tag, "/idle_oe"}, 32'(bus_a.Data_oe), 32'd0);
  endtask

  // Leaves the read asserted so the caller can extend or redirect it.
  task automatic do_read(input logic [19:0] addr, input logic ub, input logic lb, input string tag);
    logic [15:0] exp;
    exp = exp_read(addr, ub, lb);
    A = addr; UB = ub; LB = lb; CE = 1'b0; OE = 1'b0; WE = 1'b1;
    step();
    chk({tag, "/rerr"}, 32'(bus_a.Range_err), 32'(addr >= 20'(DEP)));
    chk({tag, "/oe0"}, 32'(bus_a.Data_oe), 32'd0);
    for (int k = 1; k < RL; k++) begin
      step();
      chk({tag, "/oe_early"}, 32'(bus_a.Data_oe), 32'd0);
      chk({tag, "/rerr_once"}, 32'(bus_a.Range_err), 32'd0);
    end
    step();
    chk({tag, "/oe"}, 32'(bus_a.Data_oe), 32'd1);
    chk({tag, "/data"}, 32'(bus_a.Data_out), 32'(exp));
  endtask

  task automatic switch_addr(input logic [19:0] addr, input string tag);
    logic [15:0] exp;
    exp = exp_read(addr, UB, LB);
    A = addr;
    step();
    chk({tag, "/oe_drop"}, 32'(bus_a.Data_oe), 32'd0);
    for (int k = 1; k < RL; k++) begin
      step();
      chk({tag, "/oe_early"}, 32'(bus_a.Data_oe), 32'd0);
    end
    step();
    chk({tag, "/oe"}, 32'(bus_a.Data_oe), 32'd1);
    chk({tag, "/data"}, 32'(bus_a.Data_out), 32'(exp));
  endtask

  // Data_in is corrupted after the first cycle so a repeated commit would show.
  task automatic do_write(input logic [19:0] addr, input logic [15:0] data, input logic ub,
                          input logic lb, input int hold, input string tag);
    A = addr; Data_in = data; UB = ub; LB = lb; CE = 1'b0; WE = 1'b0;
    OE = 1'($urandom_range(0, 1));
    step();
    chk({tag, "/rerr"}, 32'(bus_a.Range_err), 32'(addr >= 20'(DEP)));
    chk({tag, "/oe"}, 32'(bus_a.Data_oe), 32'd0);
    for (int k = 1; k < hold; k++) begin
      Data_in = ~data;
      step();
      chk({tag, "/rerr_once"}, 32'(bus_a.Range_err), 32'd0);
    end
    model_write(addr, data, ub, lb);
  endtask

  function automatic logic [19:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 20'h400 + 20'($urandom_range(0, 15));
      1:       return {4'hF, 16'($urandom)};
      default: return 20'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int   n;
    logic seen;
    int   waited;

    A = '0; CE = 1'b1; UB = 1'b0; LB = 1'b0; OE = 1'b1; WE = 1'b1; Data_in = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < DEP; i++) mem_m[i] = 16'h0000;
    step();
    chk("rst/dout", 32'(bus_a.Data_out), 32'h0);
    chk("rst/oe", 32'(bus_a.Data_oe), 32'd0);
    chk("rst/rerr", 32'(bus_a.Range_err), 32'd0);
    chk("rst/busy_a", 32'(bus_a.Busy), 32'd1);
    chk("rst/busy_b", 32'(bus_b.Busy), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    // Power-on clear: requests during Busy must be ignored.
    n = 1; seen = 1'b0;
    while (bus_a.Busy && n < 2000) begin
      if (n == 100) begin A = 20'h00010; CE = 1'b0; OE = 1'b0; WE = 1'b1; end
      if (n == 500) A = 20'h00400;
      if (n == 900) CE = 1'b1;
      step();
      if (bus_a.Data_oe || bus_a.Range_err) seen = 1'b1;
      if (bus_a.Busy) n++;
    end
    chk("clear/busy_len", 32'(n), 32'(DEP));
    chk("clear/ignored", 32'(seen), 32'd0);
    chk("clear/busy_off", 32'(bus_a.Busy), 32'd0);
    do_read(20'h00010, 1'b0, 1'b0, "clear/read"); idle("clear");

    do_write(20'h00005, 16'hBEEF, 1'b0, 1'b0, 3, "wr5"); idle("wr5");
    do_read(20'h00005, 1'b0, 1'b0, "rd5"); idle("rd5");

    do_write(20'h00007, 16'hABCD, 1'b0, 1'b0, 1, "wr7a"); idle("wr7a");
    do_write(20'h00007, 16'h1234, 1'b0, 1'b1, 2, "wr7b"); idle("wr7b");
    do_read(20'h00007, 1'b0, 1'b0, "rd7");
    UB = 1'b1;
    step();
    chk("rd7/mask_live", 32'(bus_a.Data_out), 32'h00CD);
    idle("rd7");
    do_read(20'h00007, 1'b1, 1'b0, "rd7ub"); idle("rd7ub");

    do_write(20'h00001, 16'h1111, 1'b0, 1'b0, 1, "wr1"); idle("wr1");
    do_write(20'h00002, 16'h2222, 1'b0, 1'b0, 1, "wr2"); idle("wr2");
    A = 20'h00001; UB = 1'b0; LB = 1'b0; CE = 1'b0; OE = 1'b0; WE = 1'b1;
    step();
    switch_addr(20'h00002, "achg_early"); idle("achg_early");
    do_read(20'h00001, 1'b0, 1'b0, "rd1");
    switch_addr(20'h00002, "achg_late"); idle("achg_late");

    do_read(20'h00400, 1'b0, 1'b0, "oor_rd"); idle("oor_rd");
    do_write(20'h00400, 16'hFFFF, 1'b0, 1'b0, 1, "oor_wr"); idle("oor_wr");
    do_read(20'h00000, 1'b0, 1'b0, "alias0"); idle("alias0");
    do_read(20'hFFFFF, 1'b0, 1'b0, "oor_top"); idle("oor_top");

    // Read turning straight into a write, then a write straight into a read.
    do_read(20'h00005, 1'b0, 1'b0, "r2w");
    A = 20'h00006; Data_in = 16'h7777; WE = 1'b0;
    step();
    chk("r2w/oe_drop", 32'(bus_a.Data_oe), 32'd0);
    model_write(20'h00006, 16'h7777, 1'b0, 1'b0);
    idle("r2w");
    do_read(20'h00006, 1'b0, 1'b0, "rd6"); idle("rd6");
    do_write(20'h00008, 16'h4321, 1'b0, 1'b0, 1, "w2r");
    WE = 1'b1; OE = 1'b0;
    waited = 0;
    while (!bus_a.Data_oe && waited < RL + 2) begin step(); waited++; end
    chk("w2r/oe", 32'(bus_a.Data_oe), 32'd1);
    chk("w2r/data", 32'(bus_a.Data_out), 32'h4321);
    idle("w2r");

    // Reset mid-read on the no-clear instance must keep memory.
    do_write(20'h00003, 16'h5A5A, 1'b0, 1'b0, 1, "wr3"); idle("wr3");
    A = 20'h00003; CE = 1'b0; OE = 1'b0; WE = 1'b1;
    step();
    step();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    chk("rstmid/b_oe", 32'(bus_b.Data_oe), 32'd0);
    chk("rstmid/b_dout", 32'(bus_b.Data_out), 32'h0);
    chk("rstmid/b_busy", 32'(bus_b.Busy), 32'd0);
    chk("rstmid/a_data", 32'(bus_a.Data_out), 32'h5A5A);
    idle("rstmid");
    do_read(20'h00003, 1'b0, 1'b0, "rd3");
    chk("rd3/b_oe", 32'(bus_b.Data_oe), 32'd1);
    chk("rd3/b_data", 32'(bus_b.Data_out), 32'h5A5A);
    idle("rd3");

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(rand_addr(), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(1, 3), "rnd_wr");
      else
        do_read(rand_addr(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_rd");
      idle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the SLC-3 SRAM control bus.
- Receives the CPU's 20-bit address, active-low CE/UB/LB/OE/WE strobes and 16-bit write data.
- Returns read data after a fixed, parameterised latency.
- Replaces the behavioural memory model with a synthesizable, cycle-accurate responder that has byte-lane writes, a power-on clear sequence and address range checking.

Parameters:
- ADDR_W, 20, width of the address bus A.
- DEPTH, 1024, number of 16-bit words implemented; valid word addresses are 0..DEPTH-1.
- READ_LAT, 2, number of cycles from the first sampled read request to valid Data_out; legal range 1..7.
- INIT_CLEAR, 1, when 1, memory is zero-filled after every reset.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- A  input  ADDR_W  word address from the CPU.
- CE  input  1  chip enable, active low.
- UB  input  1  upper byte enable [15:8], active low.
- LB  input  1  lower byte enable [7:0], active low.
- OE  input  1  output enable, active low.
- WE  input  1  write enable, active low.
- Data_in  input  16  write data from the CPU.
- Data_out  output  16  read data, registered.
- Data_oe  output  1  high when Data_out is valid and should drive the shared bus.
- Busy  output  1  high while the clear sequence runs; requests are ignored while high.
- Range_err  output  1  one-cycle pulse on any access with A >= DEPTH.

Behaviour:
- Reset values: Data_out=0x0000, Data_oe=0, Range_err=0, Busy=INIT_CLEAR.
  - FSM goes to S_CLEAR if INIT_CLEAR=1, otherwise S_IDLE.
  - Reset mid-operation aborts any read or write. Memory contents are preserved when INIT_CLEAR=0.
- Request decode (sampled each cycle):
  - write = !CE & !WE.
  - read = !CE & !OE & WE.
  - WE has priority over OE.
  - CE=1 means no request.
- S_CLEAR:
  - Counter walks 0..DEPTH-1, writing 0x0000 to one word per cycle; Busy=1.
  - After writing word DEPTH-1, go to S_IDLE; Busy falls that same edge. Total Busy duration is exactly DEPTH cycles.
  - All bus requests are ignored: Data_oe=0, no writes, no Range_err.
- S_IDLE:
  - On read: latch the address, load the latency counter with READ_LAT-1, go to S_READ.
  - On write:
    - Commit immediately on that edge with byte masks: UB=0 writes [15:8], LB=0 writes [7:0]; both high writes nothing.
    - Then go to S_WHOLD.
- S_READ:
  - The counter decrements each cycle. Data_out and Data_oe=1 are registered READ_LAT cycles after the request was first sampled.
  - Data_out = mem[addr] with [15:8] forced to 0 if UB=1 and [7:0] forced to 0 if LB=1. Byte masks are re-evaluated every cycle while Data_oe=1.
  - If A changes while the read stays asserted: reload the counter and drop Data_oe; the new data appears READ_LAT cycles later.
  - If the request drops (CE=1 or OE=1): Data_oe=0 on the next edge; go to S_IDLE. Data_out holds its last value.
  - If WE goes low while in S_READ: drop Data_oe and treat the cycle as a new write request from S_IDLE.
- S_WHOLD:
  - Exactly one commit per write assertion; no further writes while CE=0 and WE=0 stay held.
  - Return to S_IDLE when CE=1 or WE=1. Data_oe=0 throughout.
- Out of range (A >= DEPTH):
  - Read returns 0x0000 with normal latency and Data_oe.
  - Write is dropped.
  - Range_err pulses high for one cycle on the request's first sampled cycle only.
- Back-to-back:
  - A read immediately following a write to the same address returns the newly written value (write-first).
  - A write immediately following a read needs no idle cycle.
- Width rules: comparisons use the full ADDR_W bits; the memory index uses the low clog2(DEPTH) bits only after the range check passes.

Decomposition:
- Shared package: add the state enum (S_CLEAR, S_IDLE, S_READ, S_WHOLD) and the decoded request enum (REQ_NONE, REQ_READ, REQ_WRITE) to lc3b_types. Add default constants MEM_DEPTH=1024 and MEM_READ_LAT=2.
- Sub-module sram_responder_array: single-port DEPTH x 16 RAM with per-byte write enables and a registered read port. It also serves the clear-sequence writes.

Test Plan:
- Clear sequence: Reset high 1 cycle, INIT_CLEAR=1, DEPTH=1024 -> Busy=1 for exactly 1024 cycles. A read of 0x00010 issued during Busy gives Data_oe=0. After Busy falls, a read of 0x00010 returns 0x0000.
- Basic read/write: write 0xBEEF to 0x00005 with UB=LB=0, WE low for 3 cycles -> exactly one commit. Then a read of 0x00005 -> Data_oe rises 2 cycles after the request and Data_out=0xBEEF.
- Byte lanes: write 0x1234 to 0x00007 with LB=1, over an existing 0xABCD -> the word becomes 0x12CD. A read with UB=1 -> Data_out=0x00CD.
- Address change mid-read: mem[1]=0x1111 and mem[2]=0x2222. Read 0x00001, then switch A to 0x00002 one cycle later -> Data_oe drops and 0x2222 appears READ_LAT cycles after the switch.
- Out of range: read of A=0x00400 -> Range_err pulses for 1 cycle and Data_out=0x0000. A write of 0xFFFF to 0x00400 leaves mem[0x000] unchanged (no aliasing).
- Reset mid-read with INIT_CLEAR=0: write 0x5A5A to 0x00003, start a read, assert Reset -> Data_oe=0 on the next edge. A read after reset returns 0x5A5A.
